four_way_demux: RTL and testbench
=================================

// Module: four_way_demux
// PURPOSE
//   Registered 1-to-4 demultiplexer: routes data input a to exactly one of outputs b/c/d/e,
//   chosen by the 2-bit select {s3,s2}. Non-selected outputs are driven to zero.
//   Used as the channel-steering stage feeding four downstream consumers.
//   One clock cycle of latency, with a per-channel valid strobe.
// PARAMETERS
//   WIDTH   1  data width of a, b, c, d, e (>=1)
//   CNT_W   8  width of per-channel route counters (used only with DEMUX_ROUTE_COUNT_EN)
// PORTS
//   clk       in   1      clock, rising-edge active
//   rst       in   1      reset, asynchronous, active-high
//   a         in   WIDTH  data input
//   s2        in   1      select bit 0 (LSB)
//   s3        in   1      select bit 1 (MSB)
//   in_valid  in   1      a/s2/s3 qualify this cycle
//   b         out  WIDTH  channel 0 data ({s3,s2}=00)
//   c         out  WIDTH  channel 1 data ({s3,s2}=01)
//   d         out  WIDTH  channel 2 data ({s3,s2}=10)
//   e         out  WIDTH  channel 3 data ({s3,s2}=11)
//   vld       out  4      per-channel valid, bit0=b .. bit3=e
// BEHAVIOUR
//   - Reset (rst=1, asynchronous): b=c=d=e=0, vld=4'b0000; all counters 0.
//   - Each rising clk edge with in_valid=1: sel={s3,s2}; selected output <= a;
//     the other three outputs <= 0; vld <= one-hot(sel).
//   - Rising clk edge with in_valid=0: all outputs <= 0; vld <= 0.
//   - Latency: exactly 1 cycle from input sample to output. No back-pressure;
//     a new sample is accepted on every cycle.
//   - Truth table (registered): 00->b=a, 01->c=a, 10->d=a, 11->e=a.
//     Zero data on the selected channel still asserts that channel's vld bit.
//   - vld is always one-hot or zero; at most one of b..e is nonzero at any time.
//   - X/Z on s2/s3 while in_valid=1 is a protocol error. Outputs are not specified;
//     an assertion flags it in simulation.
//   - Reset asserted mid-stream clears outputs immediately, without waiting for clk.
//     The first sample after reset deassertion appears one edge after it is sampled.
// CONFIGURATION
//   - Macro DEMUX_ROUTE_COUNT_EN defined:
//     - Adds input cnt_clr (1 bit) and output cnt (4*CNT_W bits), one slice per channel,
//       b in the LSB slice.
//     - A channel counter increments on each edge where in_valid=1 and that channel
//       is selected.
//     - Counters saturate at all-ones.
//     - cnt_clr=1 zeroes all counters synchronously; clear wins over increment.
//     - rst also zeroes the counters.
//   - Macro not defined: no cnt_clr or cnt ports, and no counter logic.
// TESTING
//   1. rst=1 then 0, in_valid=0 -> b=c=d=e=0, vld=0000.
//   2. WIDTH=1, in_valid=1, sweep {s3,s2,a} 000..111 one per cycle
//      -> next cycle only the selected output equals a: a=1 gives b,c,d,e=1
//      for sel 00,01,10,11 respectively; vld=0001,0010,0100,1000.
//   3. WIDTH=8, a=8'hA5, sel=10, then in_valid=0
//      -> d=8'hA5, vld=0100 for one cycle, then all outputs 0.
//   4. Drive sel=11, a=1 continuously, assert rst between edges
//      -> e drops to 0 immediately; after release, e=1 one edge later.
//   5. DEMUX_ROUTE_COUNT_EN, CNT_W=8: 300 valid samples on sel=01 -> c counter=255
//      and other counters=0; cnt_clr=1 and in_valid=1 in the same cycle -> counters=0.
//   6. Every cycle of every test: vld is one-hot or zero, and the non-selected outputs are 0.

Source files
------------

// File: rtl/four_way_demux.sv
// Registered 1-to-4 demultiplexer with per-channel valid strobes and one cycle of latency.
// Optional per-channel saturating route counters are enabled by defining DEMUX_ROUTE_COUNT_EN.
module four_way_demux #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic             s2,
  input  logic             s3,
  input  logic             in_valid,
`ifdef DEMUX_ROUTE_COUNT_EN
  input  logic             cnt_clr,
  output logic [4*CNT_W-1:0] cnt,
`endif
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [3:0]       vld
);

  logic [1:0] sel;
  logic [3:0] hit;

  assign sel = {s3, s2};

  // One-hot channel strobe for this cycle; all zero when the input is idle.
  always_comb begin
    hit = 4'b0000;
    if (in_valid) hit = 4'b0001 << sel;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b   <= '0;
      c   <= '0;
      d   <= '0;
      e   <= '0;
      vld <= 4'b0000;
    end else begin
      b   <= hit[0] ? a : '0;
      c   <= hit[1] ? a : '0;
      d   <= hit[2] ? a : '0;
      e   <= hit[3] ? a : '0;
      vld <= hit;
    end
  end

`ifdef DEMUX_ROUTE_COUNT_EN
  // Channel 0 (b) occupies the least significant counter slice.
  for (genvar i = 0; i < 4; i++) begin : g_route_cnt
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
      end else if (cnt_clr) begin
        cnt_q <= '0;
      end else if (hit[i] && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    assign cnt[i*CNT_W +: CNT_W] = cnt_q;
  end
`endif

`ifndef SYNTHESIS
  // An unknown select while the input is valid would steer data to an undefined channel.
  sel_known_a: assert property (@(posedge clk) disable iff (rst)
    in_valid |-> !$isunknown({s3, s2}));
`endif

endmodule

// File: tb/tb_four_way_demux.sv
// Self-checking bench for four_way_demux: WIDTH=1 and WIDTH=8 instances share control inputs,
// a queue scoreboard holds the expected registered outputs of both.
module tb_four_way_demux;

  localparam int CNT_W = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       s2, s3, in_valid;
  logic       a1;
  logic [7:0] a8;
  logic       b1, c1, d1, e1;
  logic [3:0] vld1;
  logic [7:0] b8, c8, d8, e8;
  logic [3:0] vld8;
`ifdef DEMUX_ROUTE_COUNT_EN
  logic               cnt_clr;
  logic [4*CNT_W-1:0] cnt1, cnt8;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [43:0] exp_q[$];

  four_way_demux #(.WIDTH(1), .CNT_W(CNT_W)) dut1 (
    .clk(clk), .rst(rst), .a(a1), .s2(s2), .s3(s3), .in_valid(in_valid),
`ifdef DEMUX_ROUTE_COUNT_EN
    .cnt_clr(cnt_clr), .cnt(cnt1),
`endif
    .b(b1), .c(c1), .d(d1), .e(e1), .vld(vld1)
  );

  four_way_demux #(.WIDTH(8), .CNT_W(CNT_W)) dut8 (
    .clk(clk), .rst(rst), .a(a8), .s2(s2), .s3(s3), .in_valid(in_valid),
`ifdef DEMUX_ROUTE_COUNT_EN
    .cnt_clr(cnt_clr), .cnt(cnt8),
`endif
    .b(b8), .c(c8), .d(d8), .e(e8), .vld(vld8)
  );

  always #5 clk = ~clk;

  // Reference behaviour: the selected channel carries the data, everything else is zero.
  function automatic logic [43:0] model(input logic v, input logic [1:0] sel,
                                        input logic a_1, input logic [7:0] a_8);
    logic [7:0] ch8 [4];
    logic       ch1 [4];
    logic [3:0] v4;
    for (int i = 0; i < 4; i++) begin
      v4[i]  = v && (sel == 2'(i));
      ch8[i] = v4[i] ? a_8 : 8'h00;
      ch1[i] = v4[i] ? a_1 : 1'b0;
    end
    return {ch8[0], ch8[1], ch8[2], ch8[3], v4, ch1[0], ch1[1], ch1[2], ch1[3], v4};
  endfunction

  function automatic logic [43:0] observed();
    return {b8, c8, d8, e8, vld8, b1, c1, d1, e1, vld1};
  endfunction

  // Drive one sample, queue its expected result, and step to just after the capturing edge.
  task automatic drive_cycle(input logic v, input logic [1:0] sel,
                             input logic a_1, input logic [7:0] a_8);
    in_valid = v;
    {s3, s2} = sel;
    a1       = a_1;
    a8       = a_8;
    exp_q.push_back(model(v, sel, a_1, a_8));
    @(posedge clk);
    #1;
  endtask

  // Structural invariants on every cycle: vld one-hot or zero, unselected channels zero.
  always @(negedge clk) begin
    n_checks++;
    if (($countones(vld8) > 1) || ($countones(vld1) > 1) ||
        (!vld8[0] && b8 != 8'h00) || (!vld8[1] && c8 != 8'h00) ||
        (!vld8[2] && d8 != 8'h00) || (!vld8[3] && e8 != 8'h00) ||
        (!vld1[0] && b1) || (!vld1[1] && c1) || (!vld1[2] && d1) || (!vld1[3] && e1)) begin
      n_fail++;
      $display("FAIL invariant @%0t: vld8=%b b8..e8=%h %h %h %h vld1=%b b1..e1=%b%b%b%b, required one-hot vld and zero unselected outputs",
               $time, vld8, b8, c8, d8, e8, vld1, b1, c1, d1, e1);
    end
  end

  task automatic test_reset();
    logic [43:0] exp;
    rst      = 1'b1;
    in_valid = 1'b0;
    {s3, s2} = 2'b00;
    a1       = 1'b0;
    a8       = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (observed() !== 44'h0) begin
      n_fail++;
      $display("FAIL reset_held: got %h required %h", observed(), 44'h0);
    end
`ifdef DEMUX_ROUTE_COUNT_EN
    n_checks++;
    if ({cnt8, cnt1} !== '0) begin
      n_fail++;
      $display("FAIL reset_counters: got %h / %h required 0", cnt8, cnt1);
    end
`endif
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b0, 2'b00, 1'b0, 8'h00);
      exp = exp_q.pop_front();
      n_checks++;
      if (observed() !== exp) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: got %h required %h", i, observed(), exp);
      end
    end
  endtask

  task automatic test_sweep();
    logic [43:0] exp;
    logic [2:0]  pat;
    for (int i = 0; i < 8; i++) begin
      pat = 3'(i);
      drive_cycle(1'b1, pat[2:1], pat[0], 8'h11 * 8'(i + 1));
      exp = exp_q.pop_front();
      n_checks++;
      if (observed() !== exp) begin
        n_fail++;
        $display("FAIL sweep {s3,s2,a}=%b: got %h required %h", pat, observed(), exp);
      end
    end
  endtask

  task automatic test_width8_pulse();
    logic [43:0] exp;
    drive_cycle(1'b1, 2'b10, 1'b1, 8'hA5);
    exp = exp_q.pop_front();
    n_checks++;
    if ((observed() !== exp) || (d8 !== 8'hA5) || (vld8 !== 4'b0100)) begin
      n_fail++;
      $display("FAIL pulse_d: got %h (d8=%h vld8=%b) required %h", observed(), d8, vld8, exp);
    end
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b0, 2'b10, 1'b1, 8'hA5);
      exp = exp_q.pop_front();
      n_checks++;
      if (observed() !== exp) begin
        n_fail++;
        $display("FAIL pulse_idle[%0d]: got %h required %h", i, observed(), exp);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [43:0] exp;
    drive_cycle(1'b1, 2'b11, 1'b1, 8'h3C);
    exp = exp_q.pop_front();
    n_checks++;
    if ((observed() !== exp) || (e1 !== 1'b1)) begin
      n_fail++;
      $display("FAIL pre_reset_e: got %h required %h", observed(), exp);
    end
    // Assert reset midway between edges; outputs must clear before any clock edge.
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (observed() !== 44'h0) begin
      n_fail++;
      $display("FAIL async_clear: got %h required %h", observed(), 44'h0);
    end
    exp_q.delete();
    #1 rst = 1'b0;
    exp_q.push_back(model(1'b1, 2'b11, 1'b1, 8'h3C));
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    n_checks++;
    if ((observed() !== exp) || (e1 !== 1'b1) || (e8 !== 8'h3C)) begin
      n_fail++;
      $display("FAIL post_reset_e: got %h required %h", observed(), exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [43:0] exp;
    for (int i = 0; i < 40; i++) begin
      drive_cycle(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      exp = exp_q.pop_front();
      n_checks++;
      if (observed() !== exp) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got %h required %h", i, observed(), exp);
      end
    end
  endtask

`ifdef DEMUX_ROUTE_COUNT_EN
  task automatic check_counts(input string name, input logic [4*CNT_W-1:0] req);
    n_checks++;
    if ((cnt8 !== req) || (cnt1 !== req)) begin
      n_fail++;
      $display("FAIL %s: got %h / %h required %h", name, cnt8, cnt1, req);
    end
  endtask

  task automatic test_route_count();
    logic [43:0] exp;
    cnt_clr = 1'b1;
    drive_cycle(1'b0, 2'b00, 1'b0, 8'h00);
    void'(exp_q.pop_front());
    cnt_clr = 1'b0;
    check_counts("cnt_initial_clear", '0);
    for (int i = 0; i < 300; i++) begin
      drive_cycle(1'b1, 2'b01, 1'(i), 8'(i));
      exp = exp_q.pop_front();
      if (i % 50 == 0) begin
        n_checks++;
        if (observed() !== exp) begin
          n_fail++;
          $display("FAIL count_data[%0d]: got %h required %h", i, observed(), exp);
        end
      end
    end
    check_counts("cnt_saturate_c", {8'd0, 8'd0, 8'd255, 8'd0});
    cnt_clr = 1'b1;
    drive_cycle(1'b1, 2'b01, 1'b1, 8'h77);
    cnt_clr = 1'b0;
    exp = exp_q.pop_front();
    n_checks++;
    if (observed() !== exp) begin
      n_fail++;
      $display("FAIL clear_cycle_data: got %h required %h", observed(), exp);
    end
    check_counts("cnt_clear_wins", '0);
    drive_cycle(1'b1, 2'b10, 1'b0, 8'h00);
    void'(exp_q.pop_front());
    check_counts("cnt_after_clear", {8'd0, 8'd1, 8'd0, 8'd0});
  endtask
`endif

  initial begin
`ifdef DEMUX_ROUTE_COUNT_EN
    cnt_clr = 1'b0;
`endif
    test_reset();
    test_sweep();
    test_width8_pulse();
    test_async_reset();
    test_back_to_back();
`ifdef DEMUX_ROUTE_COUNT_EN
    test_route_count();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
